video_compositor: RTL and testbench
===================================

# video_compositor

Parametrised, pipelined pixel compositor that replaces the fixed five-source combinational priority mux in the video path. It merges `LAYERS` colour sources over a background with fixed priority, where index 0 wins. It adds run-time layer masking, frame-synchronous blinking and per-frame layer-overlap (collision) flags for the game logic. It delays hsync/vsync by the same latency as the pixels, so the sits between the sprite/tile generators and the VGA output pins.

## Interface
Parameters:
- `COLOR_W`, default 6: bits per pixel colour (RRGGBB at default).
- `LAYERS`, default 4: number of overlay layers, legal range 1..8; layer 0 has the highest priority.
- `BLINK_LOG2`, default 5: blink half-period is 2^(BLINK_LOG2-1) frames; legal range 1..8.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_frame`  in  1  high in the visible area.
- `hsync_in`, `vsync_in`  in  1 each  raw syncs from the timing generator.
- `frame_start`  in  1  one-cycle pulse per frame, issued in blanking.
- `background`  in  COLOR_W  colour used when no layer is active.
- `layer_color`  in  LAYERS*COLOR_W  packed colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- `layer_en`  in  LAYERS  per-layer pixel-active flags.
- `cfg_we`  in  1  loads both mask registers.
- `cfg_layer_mask`  in  LAYERS  new layer mask; 1 = layer allowed.
- `cfg_blink_mask`  in  LAYERS  new blink mask; 1 = layer blinks.
- `pix_out`  out  COLOR_W  composited pixel, registered.
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed to match `pix_out`.
- `collision`  out  LAYERS  overlap flags for the previous frame, registered.

## Operation
- State:
  - `layer_mask`: reset value all ones.
  - `blink_mask`: reset value all zeros.
  - `frame_cnt`: BLINK_LOG2 bits, reset value 0.
  - `blink_phase`: equals `frame_cnt[BLINK_LOG2-1]`.
  - `coll_acc`: LAYERS bits, reset value 0.
  - Two pipeline stages.
- Configuration:
  - `cfg_we`=1 loads both masks at the clock edge.
  - The new masks affect input pixels from the following cycle onward.
- Frame counter:
  - `frame_cnt` increments modulo 2^BLINK_LOG2 on each `frame_start`.
  - The updated `blink_phase` applies from the next cycle.
- Effective enable, computed in the input cycle:
  - `eff[i] = layer_en[i] & layer_mask[i] & ~(blink_mask[i] & blink_phase) & in_frame`.
- Stage 1 registers: `layer_color`, `eff`, `background`, `in_frame`, `hsync_in`, `vsync_in`.
- Stage 2 computes and registers the output pixel:
  - `in_frame`=0 gives 0.
  - Otherwise, the colour of the lowest-index i with `eff[i]`=1.
  - Otherwise, `background`.
- Collision:
  - `hit[i] = eff[i] & |(eff & ~(1<<i))`, computed from the input cycle.
  - Each cycle, `coll_acc <= coll_acc | hit`.
  - On `frame_start`, `collision <= coll_acc | hit` and `coll_acc <= 0`.
  - Masked or blinked-off layers never register a collision.
- With `LAYERS`=1, `collision` is constant 0.

## Timing
- Pixel latency is exactly 2 cycles from inputs to `pix_out`, `hsync_out` and `vsync_out`, with throughput of one pixel per clock.
- `collision` changes only on the edge that samples `frame_start`, and holds for the whole frame.
- Reset, whenever `rst_n`=0 at an edge (including mid-frame):
  - `pix_out`=0, `hsync_out`=0, `vsync_out`=0, `collision`=0.
  - All pipeline registers, `frame_cnt` and `coll_acc` are cleared; masks return to their reset values.
  - The first valid output appears 2 cycles after `rst_n` rises.
- Simultaneous `cfg_we` and pixel in the same cycle: that pixel uses the old masks.
- Simultaneous `frame_start` and an overlap: the overlap is counted in the frame being closed, not in the new `coll_acc`.
- `frame_cnt` wraps from 2^BLINK_LOG2-1 to 0 without glitching `blink_phase` beyond its normal toggle.

## Test plan
- Priority and latency:
  - Stimulus: `LAYERS`=4, `in_frame`=1, `layer_en`=4'b1010, colours L1=0x11 and L3=0x33, `background`=0x2A.
  - Required: `pix_out`=0x11 exactly 2 cycles later.
  - With `layer_en`=0: `pix_out`=0x2A.
- Blanking:
  - Stimulus: `in_frame`=0 with all `layer_en`=1.
  - Required: `pix_out`=0 two cycles later; `hsync_out`/`vsync_out` equal the inputs delayed by 2 cycles.
- Masking:
  - Stimulus: `cfg_we` with `cfg_layer_mask`=4'b1110 while `layer_en`=4'b0011.
  - Required: the same-cycle pixel shows L0; later pixels show L1.
- Blink:
  - Stimulus: `BLINK_LOG2`=2, `blink_mask`=4'b0001, `layer_en`=4'b0001.
  - Required: L0 is visible for frames 0-1, background for frames 2-3, and L0 again at frame 4 after the wrap.
- Collision:
  - Stimulus: `layer_en`=4'b0101 for one in-frame cycle, then `frame_start`.
  - Required: `collision`=4'b0101.
  - Next frame with no overlap: `collision`=0.
  - Overlap in the `frame_start` cycle itself is reported in the same update.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 for 1 cycle during active pixels.
  - Required: all outputs are 0 on the following edge and the masks are back to their defaults.

Source files
------------

// File: rtl/video_compositor.sv
// Two-stage pixel compositor: fixed-priority layer merge over a background, with run-time
// layer masking, frame-synchronous blinking and per-frame layer-overlap flags.
module video_compositor #(
    parameter int unsigned COLOR_W    = 6,
    parameter int unsigned LAYERS     = 4,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_frame,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        frame_start,
    input  logic [COLOR_W-1:0]          background,
    input  logic [LAYERS*COLOR_W-1:0]   layer_color,
    input  logic [LAYERS-1:0]           layer_en,
    input  logic                        cfg_we,
    input  logic [LAYERS-1:0]           cfg_layer_mask,
    input  logic [LAYERS-1:0]           cfg_blink_mask,
    output logic [COLOR_W-1:0]          pix_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic [LAYERS-1:0]           collision
);

    logic [LAYERS-1:0]         layer_mask;
    logic [LAYERS-1:0]         blink_mask;
    logic [BLINK_LOG2-1:0]     frame_cnt;
    logic                      blink_phase;
    logic [LAYERS-1:0]         coll_acc;

    logic [LAYERS-1:0]         eff;
    logic [LAYERS-1:0]         hit;
    logic [LAYERS-1:0]         others;

    logic [LAYERS*COLOR_W-1:0] s1_color;
    logic [LAYERS-1:0]         s1_eff;
    logic [COLOR_W-1:0]        s1_background;
    logic                      s1_in_frame;
    logic                      s1_hsync;
    logic                      s1_vsync;

    logic [COLOR_W-1:0]        pix_next;

    assign blink_phase = frame_cnt[BLINK_LOG2-1];

    always_comb begin
        eff = layer_en & layer_mask & ~(blink_mask & {LAYERS{blink_phase}})
              & {LAYERS{in_frame}};
    end

    // A layer hits when it is effective and at least one other layer is effective too.
    always_comb begin
        hit    = '0;
        others = '0;
        for (int i = 0; i < int'(LAYERS); i++) begin
            others    = eff;
            others[i] = 1'b0;
            hit[i]    = eff[i] & (|others);
        end
    end

    // Scan from lowest priority upward so layer 0 overrides everything else.
    always_comb begin
        pix_next = s1_background;
        for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
            if (s1_eff[i]) begin
                pix_next = s1_color[i*COLOR_W +: COLOR_W];
            end
        end
        if (!s1_in_frame) begin
            pix_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            layer_mask <= '1;
            blink_mask <= '0;
        end else if (cfg_we) begin
            layer_mask <= cfg_layer_mask;
            blink_mask <= cfg_blink_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            coll_acc  <= '0;
            collision <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + BLINK_LOG2'(1);
            collision <= coll_acc | hit;
            coll_acc  <= '0;
        end else begin
            coll_acc  <= coll_acc | hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_color      <= '0;
            s1_eff        <= '0;
            s1_background <= '0;
            s1_in_frame   <= 1'b0;
            s1_hsync      <= 1'b0;
            s1_vsync      <= 1'b0;
        end else begin
            s1_color      <= layer_color;
            s1_eff        <= eff;
            s1_background <= background;
            s1_in_frame   <= in_frame;
            s1_hsync      <= hsync_in;
            s1_vsync      <= vsync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            pix_out   <= pix_next;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_video_compositor.sv
// Randomised scoreboard bench for video_compositor: a behavioural model queues expected
// outputs per driven cycle and a negedge monitor compares them as they fall due.
module tb_video_compositor;

    localparam int CW = 6;
    localparam int NL = 4;
    localparam int BL = 2;

    typedef struct {
        int            due;
        logic [CW-1:0] pix;
        logic          hs;
        logic          vs;
    } pix_exp_t;

    typedef struct {
        int            due;
        logic [NL-1:0] coll;
    } coll_exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_frame;
    logic             hsync_in;
    logic             vsync_in;
    logic             frame_start;
    logic [CW-1:0]    background;
    logic [NL*CW-1:0] layer_color;
    logic [NL-1:0]    layer_en;
    logic             cfg_we;
    logic [NL-1:0]    cfg_layer_mask;
    logic [NL-1:0]    cfg_blink_mask;
    logic [CW-1:0]    pix_out;
    logic             hsync_out;
    logic             vsync_out;
    logic [NL-1:0]    collision;

    video_compositor #(
        .COLOR_W    (CW),
        .LAYERS     (NL),
        .BLINK_LOG2 (BL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_frame       (in_frame),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .frame_start    (frame_start),
        .background     (background),
        .layer_color    (layer_color),
        .layer_en       (layer_en),
        .cfg_we         (cfg_we),
        .cfg_layer_mask (cfg_layer_mask),
        .cfg_blink_mask (cfg_blink_mask),
        .pix_out        (pix_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .collision      (collision)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    pix_exp_t  pq[$];
    coll_exp_t cq[$];

    // Reference model state
    logic [NL-1:0] m_lmask = '1;
    logic [NL-1:0] m_bmask = '0;
    int            m_fcnt  = 0;
    logic [NL-1:0] m_acc   = '0;
    logic [NL-1:0] m_coll  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Predict the response to the inputs currently driven, then advance one clock.
    task automatic tick();
        pix_exp_t      pe;
        coll_exp_t     ce;
        logic [NL-1:0] active;
        logic [NL-1:0] hit;
        bit            blink_off;
        bit            found;
        if (!rst_n) begin
            if (pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) begin
                pe     = pq.pop_back();
                pe.pix = '0;
                pe.hs  = 1'b0;
                pe.vs  = 1'b0;
                pq.push_back(pe);
            end
            pe.due = cyc + 2;
            pe.pix = '0;
            pe.hs  = 1'b0;
            pe.vs  = 1'b0;
            m_lmask = '1;
            m_bmask = '0;
            m_fcnt  = 0;
            m_acc   = '0;
            m_coll  = '0;
        end else begin
            blink_off = (m_fcnt % (1 << BL)) >= (1 << (BL - 1));
            for (int i = 0; i < NL; i++) begin
                active[i] = layer_en[i] && m_lmask[i] && !(m_bmask[i] && blink_off) && in_frame;
            end
            pe.due = cyc + 2;
            pe.pix = background;
            found  = 0;
            for (int i = 0; i < NL; i++) begin
                if (!found && active[i]) begin
                    pe.pix = layer_color[i*CW +: CW];
                    found  = 1;
                end
            end
            if (!in_frame) pe.pix = '0;
            pe.hs = hsync_in;
            pe.vs = vsync_in;
            hit = ($countones(active) >= 2) ? active : '0;
            if (frame_start) begin
                m_coll = m_acc | hit;
                m_acc  = '0;
                m_fcnt = (m_fcnt + 1) % (1 << BL);
            end else begin
                m_acc = m_acc | hit;
            end
            if (cfg_we) begin
                m_lmask = cfg_layer_mask;
                m_bmask = cfg_blink_mask;
            end
        end
        pq.push_back(pe);
        ce.due  = cyc + 1;
        ce.coll = m_coll;
        cq.push_back(ce);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        pix_exp_t  pe;
        coll_exp_t ce;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            pe = pq.pop_front();
            chk("pix_out", 32'(pix_out), 32'(pe.pix));
            chk("syncs", 32'({hsync_out, vsync_out}), 32'({pe.hs, pe.vs}));
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
            ce = cq.pop_front();
            chk("collision", 32'(collision), 32'(ce.coll));
        end
    end

    task automatic idle();
        in_frame    = 1'b0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        layer_en    = '0;
    endtask

    task automatic frame_pulse();
        in_frame    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_masks(input logic [NL-1:0] lm, input logic [NL-1:0] bm);
        cfg_we         = 1'b1;
        cfg_layer_mask = lm;
        cfg_blink_mask = bm;
        tick();
        cfg_we         = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        hsync_in       = 1'b0;
        vsync_in       = 1'b0;
        background     = 6'h2A;
        layer_color    = {6'h33, 6'h22, 6'h11, 6'h05};
        cfg_layer_mask = '1;
        cfg_blink_mask = '0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;

        // Priority and background
        in_frame = 1'b1;
        layer_en = 4'b1010; tick();
        layer_en = 4'b0000; tick();
        layer_en = 4'b1111; tick();
        layer_en = 4'b1100; tick();

        // Blanking with sync pass-through
        in_frame = 1'b0;
        layer_en = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            hsync_in = i[0];
            vsync_in = i[1];
            tick();
        end
        hsync_in = 1'b0;
        vsync_in = 1'b0;

        // Mask load alongside a pixel
        in_frame       = 1'b1;
        layer_en       = 4'b0011;
        set_masks(4'b1110, 4'b0000);
        repeat (2) tick();

        // Blink across the frame-counter wrap
        set_masks(4'b1111, 4'b0001);
        for (int f = 0; f < 6; f++) begin
            in_frame = 1'b1;
            layer_en = 4'b0001;
            repeat (2) tick();
            frame_pulse();
        end

        // Collision reporting
        set_masks(4'b1111, 4'b0000);
        frame_pulse();
        in_frame = 1'b1;
        layer_en = 4'b0101; tick();
        layer_en = 4'b0001; tick();
        frame_pulse();
        in_frame = 1'b1;
        layer_en = 4'b1000; repeat (2) tick();
        frame_pulse();
        in_frame    = 1'b1;
        layer_en    = 4'b0011;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        layer_en    = 4'b0000; tick();
        frame_pulse();
        tick();

        // Masked layers cannot collide
        set_masks(4'b1101, 4'b0000);
        in_frame = 1'b1;
        layer_en = 4'b0110; tick();
        frame_pulse();
        in_frame = 1'b1;
        layer_en = 4'b1111; tick();

        // Mid-frame reset restores default masks
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            in_frame       = ($urandom_range(0, 3) != 0);
            hsync_in       = 1'($urandom);
            vsync_in       = 1'($urandom);
            frame_start    = ($urandom_range(0, 11) == 0);
            background     = CW'($urandom);
            layer_color    = (NL*CW)'($urandom);
            layer_en       = NL'($urandom);
            cfg_we         = ($urandom_range(0, 19) == 0);
            cfg_layer_mask = NL'($urandom) | NL'($urandom);
            cfg_blink_mask = NL'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle();

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", pq.size() + cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
